// File: rtl/flappy_pkg.sv
// Shared constants for the Flappy Bird game-status logic: coordinate width,
// screen geometry and the active-low seven-segment digit patterns.
package flappy_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Element i holds the {g,f,e,d,c,b,a} pattern for digit i.
    localparam logic [9:0][6:0] SEG7_DIGITS = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_digit.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_digit
    import flappy_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG7_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG7_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/flappy_score_unit.sv
// Game-status block: gap-length LFSR, bird/pipe/floor collision, pass-counting
// score with saturation, and a two-digit decimal score display.
module flappy_score_unit #(
    parameter int BIRD_W    = 20,
    parameter int SCREEN_H  = flappy_pkg::SCREEN_H,
    parameter int MAX_SCORE = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pipe1_x,
    input  logic [10:0] pipe2_x,
    input  logic [10:0] pipe3_x,
    input  logic [10:0] pipe1_y0,
    input  logic [10:0] pipe2_y0,
    input  logic [10:0] pipe3_y0,
    input  logic [10:0] pipe1_y1,
    input  logic [10:0] pipe2_y1,
    input  logic [10:0] pipe3_y1,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y0,
    input  logic [10:0] bird_y1,
    output logic [9:0]  pipe_length,
    output logic [6:0]  score,
    output logic        game_over,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1
);
    import flappy_pkg::*;

    // One extra bit so bird_x + BIRD_W - 1 cannot wrap near the right edge.
    localparam int XW = COORD_W + 1;

    logic [9:0]  lfsr_q, lfsr_d;
    logic [6:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic        armed_q, armed_d;
    logic [10:0] prev_x_q [3];
    logic [10:0] prev_x_d [3];

    logic [10:0]   pipe_x  [3];
    logic [10:0]   pipe_y0 [3];
    logic [10:0]   pipe_y1 [3];
    logic [2:0]    hit, pass;
    logic          floor_hit, collide;
    logic [1:0]    pass_cnt;
    logic [7:0]    score_sum;
    logic [XW-1:0] bird_left, bird_right;
    logic [3:0]    tens, ones;

    always_comb begin
        pipe_x[0]  = pipe1_x;
        pipe_x[1]  = pipe2_x;
        pipe_x[2]  = pipe3_x;
        pipe_y0[0] = pipe1_y0;
        pipe_y0[1] = pipe2_y0;
        pipe_y0[2] = pipe3_y0;
        pipe_y1[0] = pipe1_y1;
        pipe_y1[1] = pipe2_y1;
        pipe_y1[2] = pipe3_y1;
    end

    always_comb begin
        hit        = '0;
        pass       = '0;
        bird_left  = XW'(bird_x);
        bird_right = XW'(bird_x) + XW'(BIRD_W - 1);
        floor_hit  = XW'(bird_y1) >= XW'(SCREEN_H);
        for (int i = 0; i < 3; i++) begin
            hit[i]  = (XW'(pipe_x[i]) >= bird_left) && (XW'(pipe_x[i]) <= bird_right) &&
                      ((bird_y0 < pipe_y0[i]) || (bird_y1 > pipe_y1[i]));
            pass[i] = armed_q && (prev_x_q[i] >= bird_x) && (pipe_x[i] < bird_x);
        end
        collide  = (|hit) || floor_hit;
        pass_cnt = 2'(pass[0]) + 2'(pass[1]) + 2'(pass[2]);
    end

    always_comb begin
        lfsr_d      = {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
        armed_d     = 1'b1;
        game_over_d = game_over_q | collide;
        score_sum   = 8'(score_q) + 8'(pass_cnt);
        score_d     = score_q;
        // A collision in the same cycle as a pass freezes the score.
        if (!game_over_q && !collide) begin
            score_d = (score_sum > 8'(MAX_SCORE)) ? 7'(MAX_SCORE) : score_sum[6:0];
        end
        for (int i = 0; i < 3; i++) begin
            prev_x_d[i] = pipe_x[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q      <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            armed_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                prev_x_q[i] <= '0;
            end
        end else begin
            lfsr_q      <= lfsr_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            armed_q     <= armed_d;
            for (int i = 0; i < 3; i++) begin
                prev_x_q[i] <= prev_x_d[i];
            end
        end
    end

    assign tens = 4'(score_q / 7'd10);
    assign ones = 4'(score_q % 7'd10);

    seg7_digit u_seg_ones (.bcd(ones), .seg(HEX0));
    seg7_digit u_seg_tens (.bcd(tens), .seg(HEX1));

    assign pipe_length = lfsr_q;
    assign score       = score_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_flappy_score_unit.sv
// Bench for flappy_score_unit: directed game scenarios plus randomized play,
// all checked every cycle against an arithmetic model of the game rules.
module tb_flappy_score_unit;

    localparam int BIRD_W    = 20;
    localparam int SCREEN_H  = 480;
    localparam int MAX_SCORE = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pipe_x  [3];
    logic [10:0] pipe_y0 [3];
    logic [10:0] pipe_y1 [3];
    logic [10:0] bird_x, bird_y0, bird_y1;
    logic [9:0]  pipe_length;
    logic [6:0]  score;
    logic        game_over;
    logic [6:0]  HEX0, HEX1;

    always #5 clk = ~clk;

    flappy_score_unit #(.BIRD_W(BIRD_W), .SCREEN_H(SCREEN_H), .MAX_SCORE(MAX_SCORE)) dut (
        .clk(clk), .reset(reset),
        .pipe1_x(pipe_x[0]), .pipe2_x(pipe_x[1]), .pipe3_x(pipe_x[2]),
        .pipe1_y0(pipe_y0[0]), .pipe2_y0(pipe_y0[1]), .pipe3_y0(pipe_y0[2]),
        .pipe1_y1(pipe_y1[0]), .pipe2_y1(pipe_y1[1]), .pipe3_y1(pipe_y1[2]),
        .bird_x(bird_x), .bird_y0(bird_y0), .bird_y1(bird_y1),
        .pipe_length(pipe_length), .score(score), .game_over(game_over),
        .HEX0(HEX0), .HEX1(HEX1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference game state
    int m_lfsr, m_score, m_go, m_armed;
    int m_prev [3];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int collide, passes;
        if (!reset) begin
            m_lfsr = 0; m_score = 0; m_go = 0; m_armed = 0;
            for (int i = 0; i < 3; i++) m_prev[i] = 0;
            return;
        end
        collide = (int'(bird_y1) >= SCREEN_H) ? 1 : 0;
        passes  = 0;
        for (int i = 0; i < 3; i++) begin
            if (int'(pipe_x[i]) >= int'(bird_x) && int'(pipe_x[i]) <= int'(bird_x) + BIRD_W - 1 &&
                (bird_y0 < pipe_y0[i] || bird_y1 > pipe_y1[i]))
                collide = 1;
            if (m_armed != 0 && m_prev[i] >= int'(bird_x) && int'(pipe_x[i]) < int'(bird_x))
                passes++;
        end
        if (m_go == 0 && collide == 0)
            m_score = (m_score + passes > MAX_SCORE) ? MAX_SCORE : m_score + passes;
        if (collide != 0) m_go = 1;
        for (int i = 0; i < 3; i++) m_prev[i] = int'(pipe_x[i]);
        m_armed = 1;
        m_lfsr  = ((m_lfsr << 1) & 1023) | ((((m_lfsr >> 9) & 1) ^ ((m_lfsr >> 6) & 1)) ^ 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("pipe_length", pipe_length, m_lfsr);
        chk("score", score, m_score);
        chk("game_over", game_over, m_go);
        chk("hex0", HEX0, seg_tab[m_score % 10]);
        chk("hex1", HEX1, seg_tab[m_score / 10]);
    endtask

    task automatic set_all_pipes_x(int x);
        for (int i = 0; i < 3; i++) pipe_x[i] = 11'(x);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
    endtask

    task automatic drive_triple_passes(int n);
        for (int k = 0; k < n; k++) begin
            set_all_pipes_x(100); cycle();
            set_all_pipes_x(99);  cycle();
        end
        set_all_pipes_x(600);
        cycle();
    endtask

    int lfsr_exp [8] = '{1, 3, 7, 15, 31, 63, 127, 254};

    initial begin
        bird_x = 11'd100; bird_y0 = 11'd200; bird_y1 = 11'd220;
        for (int i = 0; i < 3; i++) begin
            pipe_x[i] = 11'd600; pipe_y0[i] = 11'd150; pipe_y1[i] = 11'd300;
        end
        reset = 1'b0;
        cycle();
        cycle();
        chk("rst_length", pipe_length, 0);
        chk("rst_hex0", HEX0, 7'b1000000);
        chk("rst_hex1", HEX1, 7'b1000000);

        // LFSR sequence and period
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("lfsr_seq", pipe_length, lfsr_exp[k]);
        end
        for (int k = 9; k <= 1023; k++) begin
            cycle();
            chk("lfsr_not_ones", (pipe_length == 10'h3FF) ? 1 : 0, 0);
        end
        chk("lfsr_period", pipe_length, 0);

        // Single pass
        pipe_x[0] = 11'd101; cycle();
        pipe_x[0] = 11'd100; cycle();
        chk("pre_pass_score", score, 0);
        pipe_x[0] = 11'd99;  cycle();
        chk("pass_score", score, 1);
        chk("pass_hex1", HEX1, 7'b1000000);
        chk("pass_hex0", HEX0, 7'b1111001);

        // Pipe collision, then a pass that must not count
        bird_y0 = 11'd140; pipe_x[0] = 11'd110; cycle();
        chk("pipe_hit_go", game_over, 1);
        bird_y0 = 11'd200; pipe_x[0] = 11'd100; cycle();
        pipe_x[0] = 11'd99; cycle();
        chk("frozen_score", score, 1);
        pipe_x[0] = 11'd600;

        // Floor collision is sticky
        do_reset();
        cycle();
        bird_y1 = 11'd480; cycle();
        chk("floor_go", game_over, 1);
        bird_y1 = 11'd220; cycle(); cycle();
        chk("floor_sticky", game_over, 1);

        // Saturation with three simultaneous passes per step
        do_reset();
        drive_triple_passes(35);
        chk("sat_score", score, 99);
        chk("sat_hex1", HEX1, 7'b0010000);
        chk("sat_hex0", HEX0, 7'b0010000);

        // Score 42
        do_reset();
        drive_triple_passes(14);
        chk("s42_score", score, 42);
        chk("s42_hex1", HEX1, 7'b0011001);
        chk("s42_hex0", HEX0, 7'b0100100);

        // Collision and pass in the same cycle: collision wins
        do_reset();
        pipe_x[0] = 11'd100; cycle();
        pipe_x[0] = 11'd99; pipe_x[1] = 11'd105; bird_y0 = 11'd100; cycle();
        chk("same_cycle_score", score, 0);
        chk("same_cycle_go", game_over, 1);
        bird_y0 = 11'd200; set_all_pipes_x(600);

        // Reset mid-game with score 5 and game over
        do_reset();
        drive_triple_passes(1);
        pipe_x[2] = 11'd600;
        pipe_x[0] = 11'd100; pipe_x[1] = 11'd100; cycle();
        pipe_x[0] = 11'd99;  pipe_x[1] = 11'd99;  cycle();
        chk("mid_score5", score, 5);
        bird_y1 = 11'd480; cycle();
        chk("mid_go", game_over, 1);
        bird_y1 = 11'd220; pipe_x[0] = 11'd101;
        reset = 1'b0; cycle();
        chk("mid_rst_score", score, 0);
        chk("mid_rst_go", game_over, 0);
        chk("mid_rst_len", pipe_length, 0);
        chk("mid_rst_hex", {HEX1, HEX0}, {7'b1000000, 7'b1000000});
        reset = 1'b1; pipe_x[0] = 11'd99; cycle();
        chk("unarmed_no_score", score, 0);

        // Randomized play
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            bird_x = 11'($urandom_range(40, 300));
            for (int i = 0; i < 3; i++) begin
                pipe_x[i]  = 11'($urandom_range(0, 640));
                pipe_y0[i] = 11'($urandom_range(60, 220));
                pipe_y1[i] = pipe_y0[i] + 11'($urandom_range(80, 250));
            end
            for (int c = 0; c < 250; c++) begin
                bird_y0 = 11'($urandom_range(120, 300));
                bird_y1 = ($urandom_range(0, 60) == 0) ? 11'($urandom_range(470, 500))
                                                       : bird_y0 + 11'd20;
                for (int i = 0; i < 3; i++) begin
                    automatic int step = $urandom_range(0, 3);
                    pipe_x[i] = (int'(pipe_x[i]) < step) ? 11'd640 : pipe_x[i] - 11'(step);
                end
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flappy_score_unit.md
Name: flappy_score_unit

Overview:
- Game-status block for the Flappy Bird top level.
- Contains three functions:
  - a 10-bit pseudo-random source that supplies pipe gap lengths to the pipe generators;
  - collision detection between the bird and three pipes or the screen floor, with pass-counting score;
  - a two-digit decimal score display on HEX1/HEX0.
- All state is clocked by the 50 MHz system clock.

Parameters:
- BIRD_W, 20, bird width in pixels; the bird spans x = bird_x .. bird_x+BIRD_W-1.
- SCREEN_H, 480, floor y coordinate; bird_y1 >= SCREEN_H is a collision.
- MAX_SCORE, 99, score saturation value.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-low reset.
- pipe1_x, pipe2_x, pipe3_x  in  11  pipe column x coordinate.
- pipe1_y0, pipe2_y0, pipe3_y0  in  11  top of the pipe's open gap (inclusive).
- pipe1_y1, pipe2_y1, pipe3_y1  in  11  bottom of the pipe's open gap (inclusive).
- bird_x  in  11  bird left x.
- bird_y0  in  11  bird top y.
- bird_y1  in  11  bird bottom y.
- pipe_length  out  10  LFSR output.
- score  out  7  pipes passed, 0..99.
- game_over  out  1  sticky collision flag.
- HEX0  out  7  ones digit, active-low segments {g,f,e,d,c,b,a}.
- HEX1  out  7  tens digit, same encoding.

Behaviour:
- Reset: all outputs and registers change only on posedge clk while reset == 0.
  - pipe_length = 0, score = 0, game_over = 0.
  - prev_x registers = 0; armed = 0.
  - HEX0 = HEX1 = 7'b1000000 ("00").
- LFSR:
  - Every cycle out of reset: Q <= {Q[8:0], ~(Q[9] ^ Q[6])} (XNOR, taps 10 and 7).
  - Period is 1023; the all-ones state is unreachable from 0.
  - Sequence after reset: 0, 1, 3, 7, 15, 31, 63, 127, 254, ...
- Collision, evaluated per pipe i every cycle (combinational):
  - overlap_i = (pipe_i_x >= bird_x) && (pipe_i_x <= bird_x+BIRD_W-1); comparisons are unsigned and 12 bits wide to avoid wrap.
  - hit_i = overlap_i && ((bird_y0 < pipe_i_y0) || (bird_y1 > pipe_i_y1)).
  - floor_hit = bird_y1 >= SCREEN_H.
  - collide = hit_1 | hit_2 | hit_3 | floor_hit.
- game_over:
  - Registered; set on the cycle after collide = 1.
  - Sticky until reset; one-cycle latency.
- Scoring:
  - prev_x_i <= pipe_i_x every cycle.
  - armed <= 1 on the first cycle after reset; no scoring while armed == 0.
  - pass_i = armed && (prev_x_i >= bird_x) && (pipe_i_x < bird_x).
  - Pipe wrap (x jumping from 0 back to 640) is not a pass.
  - Each cycle, add the number of pass_i asserted (0..3) to score, saturating at MAX_SCORE.
  - Score is registered with one-cycle latency.
  - Frozen while game_over == 1, or when collide == 1 in the same cycle (the collision wins over the pass).
- Display:
  - Purely combinational from the score register: tens = score/10, ones = score%10.
  - Digit encodings 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Score is never above 99; any tens digit > 9 blanks the display (7'b1111111).
- Reset mid-game clears the score and game_over on the same edge; the LFSR restarts at 0.

Decomposition:
- Package flappy_pkg holds:
  - COORD_W = 11;
  - SCREEN_W = 640; SCREEN_H = 480;
  - the seven-segment digit constant array.
- One sub-module is natural: seg7_digit, a 4-bit BCD to 7-bit active-low decoder, instantiated twice.
- The LFSR, collision and score logic stay inline.

Test Plan:
- LFSR: release reset, observe 9 cycles -> pipe_length = 0, 1, 3, 7, 15, 31, 63, 127, 254; never 1023 over 1023 cycles, and returns to 0 after 1023 cycles.
- Pass scoring:
  - Setup: bird_x = 100, bird_y0 = 200, bird_y1 = 220; pipe1 gap 150..300; pipe1_x steps 101 -> 100 -> 99.
  - score = 1 one cycle after x = 99; HEX1 = 1000000, HEX0 = 1111001.
- Pipe collision: same setup with bird_y0 = 140 and pipe1_x = 110 -> game_over = 1 next cycle; a further pipe pass leaves score unchanged.
- Floor collision: bird_y1 = 480, no pipe overlap -> game_over = 1; deassert floor_hit -> game_over stays 1.
- Saturation and display:
  - Drive 105 passes -> score holds 99, HEX1 = HEX0 = 0010000.
  - Drive score 42 -> HEX1 = 0011001, HEX0 = 0100100.
- Reset mid-game: with score = 5 and game_over = 1, pull reset low for one edge -> score = 0, game_over = 0, pipe_length = 0, HEX = "00". A pipe at prev/current x of 101/99 on the first cycle after reset does not score (armed = 0).
